// File: rtl/bft_pkg.sv
// Shared definitions for the butterfly-fat-tree leaf logic.
//   - default network geometry (leaf count, packet width)
//   - packet field offsets: valid bit at [P_SZ-1], address below it,
//     payload in the remaining low bits
//   - leaf injection FSM state encoding
package bft_pkg;

  localparam int BFT_NUM_LEAVES = 256;
  localparam int BFT_P_SZ       = 52;

  // Address field width for a given leaf count.
  function automatic int bft_addr_w(input int num_leaves);
    return $clog2(num_leaves);
  endfunction

  // Offsets inside a full packet (valid bit included).
  function automatic int bft_valid_bit(input int p_sz);
    return p_sz - 1;
  endfunction

  // Offsets inside a packet body (valid bit excluded, P_SZ-1 bits wide).
  function automatic int bft_addr_msb(input int p_sz);
    return p_sz - 2;
  endfunction

  function automatic int bft_payload_msb(input int p_sz, input int aw);
    return p_sz - 2 - aw;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_BACKOFF
  } bft_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request at or after the priority pointer,
// wrapping from NUM_REQ-1 back to 0.
//   req_i    NUM_REQ  request bits
//   rr_i     IW       index of the highest-priority requester
//   gnt_o    NUM_REQ  one-hot grant (all zero when nothing requests)
//   idx_o    IW       index of the granted requester
//   valid_o  1        a grant was issued
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      rr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  int          k;
  logic [IW-1:0] kk;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    kk      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Walk the ring starting at the pointer; modulo done by subtraction
      // so non-power-of-two requester counts wrap correctly.
      k = int'(rr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kk = k[IW-1:0];
      if (!valid_o && req_i[kk]) begin
        valid_o   = 1'b1;
        gnt_o[kk] = 1'b1;
        idx_o     = kk;
      end
    end
  end

endmodule

// File: rtl/bft_leaf_arbiter.sv
// Leaf-side injection controller for the butterfly-fat-tree network.
// Shares one leaf port between NUM_REQ local requesters (round-robin),
// drives the registered packet onto pe_interface and re-presents it after
// BACKOFF idle cycles whenever the network signals resend.
//   clk, reset    clock; synchronous active-high reset
//   req_valid     per-requester packet available
//   req_packet    per-requester packet body (address + payload)
//   req_ready     one-hot capture strobe back to the requesters (combinational)
//   pe_interface  registered packet to the leaf, valid bit at MSB
//   resend        network rejected the packet on pe_interface
//   busy          FSM not idle (registered)
//   sent_cnt      saturating count of accepted packets
//   resend_cnt    saturating count of resend events
module bft_leaf_arbiter
  import bft_pkg::*;
#(
  parameter int NUM_LEAVES = BFT_NUM_LEAVES,
  parameter int P_SZ       = BFT_P_SZ,
  parameter int NUM_REQ    = 4,
  parameter int BACKOFF    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*(P_SZ-1)-1:0]   req_packet,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [P_SZ-1:0]               pe_interface,
  input  logic                          resend,
  output logic                          busy,
  output logic [31:0]                   sent_cnt,
  output logic [31:0]                   resend_cnt
);

  localparam int AW       = bft_addr_w(NUM_LEAVES);
  localparam int IW       = $clog2(NUM_REQ);
  localparam int ADDR_MSB = bft_addr_msb(P_SZ);
  localparam int PAY_MSB  = bft_payload_msb(P_SZ, AW);

  bft_state_e           state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [P_SZ-1:0]      hold_q, hold_d;
  logic [P_SZ-1:0]      pe_q, pe_d;
  logic [3:0]           bo_cnt_q, bo_cnt_d;
  logic                 busy_q, busy_d;
  logic [31:0]          sent_q, sent_d;
  logic [31:0]          resend_q, resend_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_valid;
  logic                 capture;
  logic [P_SZ-2:0]      body;
  logic [P_SZ-1:0]      new_pkt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .rr_i    (rr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  // A pending retry in SEND outranks new requests; BACKOFF never captures.
  assign capture = gnt_valid &&
                   ((state_q == ST_IDLE) || (state_q == ST_SEND && !resend));

  assign req_ready = capture ? gnt : '0;

  // Select the granted body and assemble {valid, address, payload}.
  always_comb begin
    body = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) body = req_packet[i*(P_SZ-1) +: P_SZ-1];
    end
    new_pkt = {1'b1, body[ADDR_MSB -: AW], body[PAY_MSB:0]};
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    hold_d   = hold_q;
    pe_d     = pe_q;
    bo_cnt_d = bo_cnt_q;
    sent_d   = sent_q;
    resend_d = resend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (capture) state_d = ST_SEND;
      end

      ST_SEND: begin
        if (resend) begin
          if (resend_q != '1) resend_d = resend_q + 32'd1;
          if (BACKOFF != 0) begin
            pe_d     = '0;
            bo_cnt_d = 4'(BACKOFF);
            state_d  = ST_BACKOFF;
          end
        end else begin
          if (sent_q != '1) sent_d = sent_q + 32'd1;
          if (!capture) begin
            pe_d    = '0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_BACKOFF: begin
        bo_cnt_d = bo_cnt_q - 4'd1;
        if (bo_cnt_q <= 4'd1) begin
          pe_d    = hold_q;
          state_d = ST_SEND;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Capture overrides the packet register regardless of the branch above.
    if (capture) begin
      hold_d = new_pkt;
      pe_d   = new_pkt;
      rr_d   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      hold_q   <= '0;
      pe_q     <= '0;
      bo_cnt_q <= '0;
      busy_q   <= 1'b0;
      sent_q   <= '0;
      resend_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      pe_q     <= pe_d;
      bo_cnt_q <= bo_cnt_d;
      busy_q   <= busy_d;
      sent_q   <= sent_d;
      resend_q <= resend_d;
    end
  end

  assign pe_interface = pe_q;
  assign busy         = busy_q;
  assign sent_cnt     = sent_q;
  assign resend_cnt   = resend_q;

endmodule
